// File: rtl/mod_pc_sequencer_if.sv
// rtl/mod_pc_sequencer_if.sv - control/status bundle between the next-PC sequencer and its datapath
interface mod_pc_sequencer_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            stall;
    logic [31:0]     instruction;
    logic            is_branch;
    logic            branch_cond;
    logic            is_j;
    logic            is_jal;
    logic            is_jr;
    logic [XLEN-1:0] rs_data;
    logic            exception;

    logic [XLEN-1:0] rg_pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] link_address;
    logic [XLEN-1:0] epc;
    logic            addr_error;
    logic [XLEN-1:0] ras_pred;
    logic            ras_valid;
    logic            ras_mispredict;
    logic [CW-1:0]   ras_count;
    logic            ras_overflow;
    logic            ras_underflow;

    modport master (
        output stall, instruction, is_branch, branch_cond, is_j, is_jal, is_jr,
               rs_data, exception,
        input  rg_pc, pc_plus4, link_address, epc, addr_error, ras_pred, ras_valid,
               ras_mispredict, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, instruction, is_branch, branch_cond, is_j, is_jal, is_jr,
               rs_data, exception,
        output rg_pc, pc_plus4, link_address, epc, addr_error, ras_pred, ras_valid,
               ras_mispredict, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/mod_pc_sequencer.sv
// rtl/mod_pc_sequencer.sv - next-PC sequencer with EPC capture, JR alignment check and return-address stack
module mod_pc_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    mod_pc_sequencer_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] EXC_PC  = XLEN'(EXC_VECTOR);
    localparam logic [CW-1:0]   CNT_MAX = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            ae_q, ae_d;
    logic            mp_q, mp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] ras_pred;
    logic [PW-1:0]   top_m1;
    logic            ras_valid;
    logic            jr_ra;
    logic            jr_misaligned;
    logic            unused_opcode;

    assign pc_plus4      = pc_q + XLEN'(4);
    assign jump_tgt      = {pc_plus4[XLEN-1:28], bus.instruction[25:0], 2'b00};
    assign br_tgt        = pc_plus4 + {{(XLEN-18){bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
    // top_q points at the next free slot, so the prediction lives one below it
    assign top_m1        = top_q - PW'(1);
    assign ras_valid     = (cnt_q != '0);
    assign ras_pred      = ras_valid ? ras_q[top_m1] : '0;
    assign jr_ra         = (bus.instruction[25:21] == 5'd31);
    assign jr_misaligned = (bus.rs_data[1:0] != 2'b00);
    assign unused_opcode = ^bus.instruction[31:26];

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        ae_d  = 1'b0;
        mp_d  = 1'b0;
        ovf_d = ovf_q;
        unf_d = unf_q;
        top_d = top_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (bus.exception) begin
            pc_d  = EXC_PC;
            epc_d = pc_q;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.is_jr && jr_misaligned) begin
            pc_d  = EXC_PC;
            epc_d = pc_q;
            ae_d  = 1'b1;
        end else if (bus.is_jr) begin
            pc_d = bus.rs_data;
            if (jr_ra) begin
                mp_d = !ras_valid || (bus.rs_data != ras_pred);
                if (ras_valid) begin
                    top_d = top_m1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
        end else if (bus.is_j || bus.is_jal) begin
            pc_d = jump_tgt;
            if (bus.is_jal) begin
                // a full stack wraps onto its oldest entry
                push  = 1'b1;
                top_d = top_q + PW'(1);
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + CW'(1);
            end
        end else if (bus.is_branch && bus.branch_cond) begin
            pc_d = br_tgt;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RST_PC;
            epc_q <= '0;
            ae_q  <= 1'b0;
            mp_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            top_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ae_q  <= ae_d;
            mp_q  <= mp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (push) ras_q[top_q] <= pc_plus4;
        end
    end

    assign bus.rg_pc          = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.link_address   = pc_plus4;
    assign bus.epc            = epc_q;
    assign bus.addr_error     = ae_q;
    assign bus.ras_pred       = ras_pred;
    assign bus.ras_valid      = ras_valid;
    assign bus.ras_mispredict = mp_q;
    assign bus.ras_count      = cnt_q;
    assign bus.ras_overflow   = ovf_q;
    assign bus.ras_underflow  = unf_q;
endmodule

// File: tb/tb_mod_pc_sequencer.sv
// tb/tb_mod_pc_sequencer.sv - scoreboard bench for the next-PC sequencer
module tb_mod_pc_sequencer;
    localparam logic [31:0] EXC = 32'h8000_0180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] pred;
        logic [2:0]  cnt;
        logic        ae;
        logic        mp;
        logic        ovf;
        logic        unf;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t        sb[$];
    logic [31:0] m_stack[$];
    logic [31:0] m_pc, m_epc;
    logic        m_ae, m_mp, m_ovf, m_unf;
    logic [31:0] links[5];
    logic [31:0] saved_pc;

    mod_pc_sequencer_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

    mod_pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .RAS_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pc    = m_pc;
        e.epc   = m_epc;
        e.cnt   = 3'(m_stack.size());
        e.valid = (m_stack.size() != 0);
        e.pred  = (m_stack.size() != 0) ? m_stack[$] : 32'h0;
        e.ae    = m_ae;
        e.mp    = m_mp;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check_eq("rg_pc", bus.rg_pc, e.pc);
        check_eq("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
        check_eq("link_address", bus.link_address, e.pc + 32'd4);
        check_eq("epc", bus.epc, e.epc);
        check_eq("addr_error", bus.addr_error, e.ae);
        check_eq("ras_mispredict", bus.ras_mispredict, e.mp);
        check_eq("ras_count", bus.ras_count, e.cnt);
        check_eq("ras_valid", bus.ras_valid, e.valid);
        check_eq("ras_pred", bus.ras_pred, e.pred);
        check_eq("ras_overflow", bus.ras_overflow, e.ovf);
        check_eq("ras_underflow", bus.ras_underflow, e.unf);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_stack.delete();
        m_ae = 1'b0; m_mp = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] ins;
        p4   = m_pc + 32'd4;
        ins  = bus.instruction;
        m_ae = 1'b0;
        m_mp = 1'b0;
        if (bus.exception) begin
            m_epc = m_pc; m_pc = EXC;
        end else if (bus.stall) begin
            m_pc = m_pc;
        end else if (bus.is_jr && bus.rs_data[1:0] != 2'b00) begin
            m_epc = m_pc; m_pc = EXC; m_ae = 1'b1;
        end else if (bus.is_jr) begin
            if (ins[25:21] == 5'd31) begin
                if (m_stack.size() == 0) begin
                    m_mp = 1'b1; m_unf = 1'b1;
                end else begin
                    m_mp = (m_stack[$] != bus.rs_data);
                    void'(m_stack.pop_back());
                end
            end
            m_pc = bus.rs_data;
        end else if (bus.is_j || bus.is_jal) begin
            if (bus.is_jal) begin
                if (m_stack.size() == 4) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
                m_stack.push_back(p4);
            end
            m_pc = {p4[31:28], ins[25:0], 2'b00};
        end else if (bus.is_branch && bus.branch_cond) begin
            m_pc = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
        end else begin
            m_pc = p4;
        end
        sb.push_back(snap());
    endtask

    task automatic drive(input logic [31:0] ins, input logic br, input logic cond, input logic j,
                         input logic jal, input logic jr, input logic [31:0] rs,
                         input logic exc, input logic stl);
        bus.instruction = ins; bus.is_branch = br; bus.branch_cond = cond; bus.is_j = j;
        bus.is_jal = jal; bus.is_jr = jr; bus.rs_data = rs; bus.exception = exc; bus.stall = stl;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    function automatic logic [31:0] jr_ins(input logic [4:0] r);
        return {6'd0, r, 21'h8};
    endfunction

    task automatic idle();
        drive(32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0); step();
    endtask

    task automatic go_to(input logic [31:0] a);
        drive(jr_ins(5'd8), 0, 0, 0, 0, 1, a, 0, 0); step();
    endtask

    initial begin
        drive(32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare(snap());
        #3 reset = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            idle();
            check_eq("seq_pc", bus.rg_pc, 32'(i * 4));
        end

        go_to(32'h100);
        drive(32'h1000_FFFF, 1, 1, 0, 0, 0, 32'h0, 0, 0); step();
        check_eq("branch_back", bus.rg_pc, 32'h100);
        drive(32'h1000_0004, 1, 1, 0, 0, 0, 32'h0, 0, 0); step();
        check_eq("branch_fwd", bus.rg_pc, 32'h114);
        drive(32'h1000_0004, 1, 0, 0, 0, 0, 32'h0, 0, 0); step();
        check_eq("branch_not_taken", bus.rg_pc, 32'h118);
        go_to(32'h1000_0000);
        drive({6'h2, 26'h40}, 0, 0, 1, 0, 0, 32'h0, 0, 0); step();
        check_eq("jump", bus.rg_pc, 32'h1000_0100);

        go_to(32'h200);
        drive({6'h3, 26'h100}, 0, 0, 0, 1, 0, 32'h0, 0, 0); step();
        check_eq("jal_pred", bus.ras_pred, 32'h204);
        drive(jr_ins(5'd31), 0, 0, 0, 0, 1, 32'h204, 0, 0); step();
        check_eq("jr31_pc", bus.rg_pc, 32'h204);
        check_eq("jr31_hit", bus.ras_mispredict, 1'b0);
        check_eq("jr31_cnt", bus.ras_count, 3'd0);
        drive(jr_ins(5'd31), 0, 0, 0, 0, 1, 32'h300, 0, 0); step();
        check_eq("empty_unf", bus.ras_underflow, 1'b1);
        check_eq("empty_mp", bus.ras_mispredict, 1'b1);
        idle();
        check_eq("mp_pulse_end", bus.ras_mispredict, 1'b0);

        for (int i = 0; i < 5; i++) begin
            links[i] = m_pc + 32'd4;
            drive({6'h3, 26'h100 + 26'(i * 16)}, 0, 0, 0, 1, 0, 32'h0, 0, 0); step();
        end
        check_eq("ovf_cnt", bus.ras_count, 3'd4);
        check_eq("ovf_flag", bus.ras_overflow, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_eq("ras_lifo", bus.ras_pred, links[4-k]);
            drive(jr_ins(5'd31), 0, 0, 0, 0, 1, links[4-k], 0, 0); step();
            check_eq("lifo_pc", bus.rg_pc, links[4-k]);
        end
        check_eq("lifo_empty", bus.ras_valid, 1'b0);

        go_to(32'h50);
        drive(jr_ins(5'd8), 0, 0, 0, 0, 1, 32'h302, 0, 0); step();
        check_eq("misalign_pc", bus.rg_pc, EXC);
        check_eq("misalign_epc", bus.epc, 32'h50);
        check_eq("misalign_ae", bus.addr_error, 1'b1);
        idle();
        check_eq("ae_pulse_end", bus.addr_error, 1'b0);
        go_to(32'h60);
        drive(32'h0, 0, 0, 0, 1, 0, 32'h0, 1, 1); step();
        check_eq("exc_stall_pc", bus.rg_pc, EXC);
        check_eq("exc_stall_epc", bus.epc, 32'h60);

        drive({6'h3, 26'h80}, 0, 0, 0, 1, 0, 32'h0, 0, 0); step();
        saved_pc = bus.rg_pc;
        drive({6'h3, 26'h90}, 0, 0, 0, 1, 0, 32'h0, 0, 1); step();
        check_eq("stall_pc", bus.rg_pc, saved_pc);
        check_eq("stall_cnt", bus.ras_count, 3'd1);
        drive(jr_ins(5'd8), 0, 0, 0, 1, 1, 32'h400, 0, 0); step();
        check_eq("jr_jal_pc", bus.rg_pc, 32'h400);
        check_eq("jr_jal_nopush", bus.ras_count, 3'd1);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] ins, rs;
            logic jr;
            ins = $urandom;
            jr  = ($urandom_range(0, 3) == 0);
            if (jr && $urandom_range(0, 1) == 1) ins[25:21] = 5'd31;
            if ($urandom_range(0, 1) == 1 && m_stack.size() != 0) rs = m_stack[$];
            else rs = {$urandom, 2'b00};
            if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
            drive(ins, $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, jr, rs, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 7) == 0);
            step();
        end

        drive({6'h3, 26'h10}, 0, 0, 0, 1, 0, 32'h0, 0, 0); step();
        #2 reset = 1'b0;
        model_reset();
        #1;
        compare(snap());
        drive(32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        idle();
        check_eq("post_reset_pc", bus.rg_pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
